// File: rtl/mdu_seq_ctrl.sv
// EX-stage sequencer for the iterative multiply/divide unit: accepts an M-op,
// counts its fixed latency while stalling the pipe, strobes result valid, aborts on flush.
module mdu_seq_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 33,
  parameter int CNT_W   = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mdu_reqE,
  input  logic [2:0] funct3E,
  input  logic       div_zeroE,
  input  logic       flush_i,
  input  logic       hold_i,
  output logic       mdu_start,
  output logic       mdu_is_div,
  output logic       mdu_abort,
  output logic       stall_mdu,
  output logic       result_validE,
  output logic       busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    is_div_d      = is_div_q;
    mdu_start     = 1'b0;
    mdu_abort     = 1'b0;
    stall_mdu     = 1'b0;
    result_validE = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mdu_reqE && !flush_i) begin
          mdu_start = 1'b1;
          stall_mdu = 1'b1;
          is_div_d  = funct3E[2];
          if (funct3E[2] && div_zeroE) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end else begin
            state_d = S_RUN;
            cnt_d   = funct3E[2] ? DIV_LD : MUL_LD;
          end
        end
      end
      S_RUN: begin
        if (flush_i) begin
          mdu_abort = 1'b1;
          state_d   = S_IDLE;
          cnt_d     = '0;
        end else begin
          stall_mdu = 1'b1;
          if (cnt_q == '0) state_d = S_DONE;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        // Hazard logic owns the freeze while hold_i keeps us here.
        if (flush_i) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          result_validE = 1'b1;
          if (!hold_i) state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // Combinational strobes must stay low while the block is held in reset.
    if (!rst_n) begin
      mdu_start = 1'b0;
      stall_mdu = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
    end
  end

  assign mdu_is_div = is_div_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Directed bench for mdu_seq_ctrl: cycle-by-cycle expectations for mul, div,
// div-by-zero, flush, hold and mid-op reset.
module tb_mdu_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mdu_reqE;
  logic [2:0] funct3E;
  logic       div_zeroE;
  logic       flush_i;
  logic       hold_i;
  logic       mdu_start, mdu_is_div, mdu_abort, stall_mdu, result_validE, busy;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mdu_seq_ctrl #(.MUL_LAT(4), .DIV_LAT(33), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .mdu_reqE(mdu_reqE), .funct3E(funct3E),
    .div_zeroE(div_zeroE), .flush_i(flush_i), .hold_i(hold_i),
    .mdu_start(mdu_start), .mdu_is_div(mdu_is_div), .mdu_abort(mdu_abort),
    .stall_mdu(stall_mdu), .result_validE(result_validE), .busy(busy)
  );

  // {start, stall, result_valid, abort, busy}
  logic [4:0] o;
  assign o = {mdu_start, stall_mdu, result_validE, mdu_abort, busy};

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    #3;
    tests++;
    assert (o === exp) else begin
      failed++;
      $error("FAIL %s: observed %b expected %b", tag, o, exp);
    end
  endtask

  task automatic chk_div(input string tag, input logic exp);
    tests++;
    assert (mdu_is_div === exp) else begin
      failed++;
      $error("FAIL %s: observed is_div %b expected %b", tag, mdu_is_div, exp);
    end
  endtask

  task automatic req(input logic r, input logic [2:0] f3, input logic dz);
    mdu_reqE = r; funct3E = f3; div_zeroE = dz;
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; hold_i = 1'b0;
    req(1'b1, 3'b000, 1'b0);
    #2;
    chk("reset_outs", 5'b00000);
    chk_div("reset_isdiv", 1'b0);
    nxt();
    req(1'b0, 3'b000, 1'b0);
    rst_n = 1'b1;
    chk("idle_after_reset", 5'b00000);

    // Mul, MUL_LAT=4
    nxt(); req(1'b1, 3'b000, 1'b0); chk("mul_c0", 5'b11000);
    for (int i = 1; i <= 4; i++) begin nxt(); chk($sformatf("mul_run_c%0d", i), 5'b01001); end
    nxt(); chk("mul_done_c5", 5'b00101);
    nxt(); req(1'b0, 3'b000, 1'b0); chk("mul_idle_c6", 5'b00000);
    chk_div("mul_isdiv", 1'b0);

    // Div, DIV_LAT=33
    nxt(); req(1'b1, 3'b110, 1'b0); chk("div_c0", 5'b11000);
    for (int i = 1; i <= 33; i++) begin
      nxt();
      if (i == 1 || i == 17 || i == 33) chk($sformatf("div_run_c%0d", i), 5'b01001);
      else #3;
    end
    chk_div("div_isdiv", 1'b1);
    nxt(); chk("div_done_c34", 5'b00101);
    nxt(); req(1'b0, 3'b000, 1'b0); chk("div_idle_c35", 5'b00000);
    chk_div("isdiv_holds_idle", 1'b1);

    // Div by zero fast path
    nxt(); req(1'b1, 3'b101, 1'b1); chk("dz_c0", 5'b11000);
    nxt(); chk("dz_done_c1", 5'b00101);
    nxt(); req(1'b0, 3'b000, 1'b0); chk("dz_idle_c2", 5'b00000);

    // Flush in RUN, then restart with a full count
    nxt(); req(1'b1, 3'b000, 1'b0); chk("fl_c0", 5'b11000);
    chk_div("fl_isdiv_c0_old", 1'b1);
    nxt(); chk("fl_c1", 5'b01001);
    chk_div("fl_isdiv_mul", 1'b0);
    nxt(); flush_i = 1'b1; chk("fl_abort_c2", 5'b00011);
    nxt(); flush_i = 1'b0; chk("fl_restart_c3", 5'b11000);
    for (int i = 4; i <= 7; i++) begin nxt(); chk($sformatf("fl_run_c%0d", i), 5'b01001); end
    nxt(); chk("fl_done_c8", 5'b00101);
    nxt(); req(1'b0, 3'b000, 1'b0); chk("fl_idle_c9", 5'b00000);

    // Hold in DONE for cycles 5-7
    nxt(); req(1'b1, 3'b001, 1'b0); chk("hd_c0", 5'b11000);
    for (int i = 1; i <= 4; i++) begin nxt(); chk($sformatf("hd_run_c%0d", i), 5'b01001); end
    for (int i = 5; i <= 7; i++) begin nxt(); hold_i = 1'b1; chk($sformatf("hd_hold_c%0d", i), 5'b00101); end
    nxt(); hold_i = 1'b0; chk("hd_rel_c8", 5'b00101);
    nxt(); req(1'b0, 3'b000, 1'b0); chk("hd_idle_c9", 5'b00000);

    // Flush in DONE: no abort; flush in IDLE: no start
    nxt(); req(1'b1, 3'b000, 1'b0); chk("fd_c0", 5'b11000);
    for (int i = 1; i <= 4; i++) begin nxt(); #3; end
    nxt(); flush_i = 1'b1; chk("fd_flush_done", 5'b00001);
    nxt(); chk("fd_flush_idle", 5'b00000);
    nxt(); flush_i = 1'b0; req(1'b0, 3'b000, 1'b0); chk("fd_idle", 5'b00000);

    // Reset mid-RUN
    nxt(); req(1'b1, 3'b000, 1'b0); chk("rs_c0", 5'b11000);
    nxt(); chk("rs_c1", 5'b01001);
    nxt(); rst_n = 1'b0; chk("rs_low_c2", 5'b00000);
    nxt(); rst_n = 1'b1; chk("rs_accept_c3", 5'b11000);
    for (int i = 4; i <= 7; i++) begin nxt(); chk($sformatf("rs_run_c%0d", i), 5'b01001); end
    nxt(); chk("rs_done_c8", 5'b00101);
    nxt(); req(1'b0, 3'b000, 1'b0); chk("rs_idle_c9", 5'b00000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
